// File: rtl/instr_fetch_unit_if.sv
// Memory read bus between the instruction fetch unit and the instruction memory.
// The fetch unit is the master and drives the request and address.
// The memory is the slave and answers with an acknowledge and the read data.
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_ack;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch controller.
// Reads the word at the current PC from a wait-stated memory using a req/ack handshake.
// Registers the returned word for decode and pulses pc_en once each fetch completes.
// A fetch that is never acknowledged, or a misaligned PC, parks the unit in HALT.
// The unit leaves HALT only on reset.
module instr_fetch_unit #(
    parameter int                      ADDR_WIDTH  = 32,
    parameter int                      INSTR_WIDTH = 32,
    parameter int                      TIMEOUT     = 255,
    parameter int                      CNT_WIDTH   = 16,
    parameter logic [INSTR_WIDTH-1:0]  NOP         = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   fetch_en,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    output logic                   pc_en,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [CNT_WIDTH-1:0]   fetch_cnt,
    output logic [1:0]             err_code,
    instr_fetch_unit_if.master     mem
);

    localparam int             TMO_WIDTH = $clog2(TIMEOUT + 1);
    localparam [TMO_WIDTH-1:0] TMO_LAST  = TMO_WIDTH'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
    localparam logic [1:0] ERR_MISALIGN  = 2'b10;

    typedef enum logic [1:0] {ISSUE, WAIT, DELIVER, HALT} state_t;

    state_t                 state, state_n;
    logic                   req_q, req_n;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_n;
    logic [INSTR_WIDTH-1:0] instr_q, instr_n;
    logic                   valid_q, valid_n;
    logic                   pc_en_q, pc_en_n;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_n;
    logic [1:0]             err_q, err_n;
    logic [TMO_WIDTH-1:0]   tmo_q, tmo_n;

    // The state register and every output register load together, so all outputs are registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ISSUE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            pc_en_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= ERR_NONE;
            tmo_q   <= '0;
        end else begin
            state   <= state_n;
            req_q   <= req_n;
            addr_q  <= addr_n;
            instr_q <= instr_n;
            valid_q <= valid_n;
            pc_en_q <= pc_en_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            tmo_q   <= tmo_n;
        end
    end

    // Next state and next register values.
    // The valid and pc_en pulses are armed on the ack edge, so both are high during DELIVER.
    always_comb begin
        state_n = state;
        req_n   = req_q;
        addr_n  = addr_q;
        instr_n = instr_q;
        valid_n = 1'b0;
        pc_en_n = 1'b0;
        cnt_n   = cnt_q;
        err_n   = err_q;
        tmo_n   = tmo_q;
        case (state)
            ISSUE: begin
                if (fetch_en) begin
                    if (pc_addr[1:0] != 2'b00) begin
                        err_n   = ERR_MISALIGN;
                        instr_n = NOP;
                        state_n = HALT;
                    end else begin
                        addr_n  = pc_addr;
                        req_n   = 1'b1;
                        tmo_n   = '0;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_ack) begin
                    instr_n = mem.mem_rdata;
                    req_n   = 1'b0;
                    valid_n = 1'b1;
                    pc_en_n = 1'b1;
                    state_n = DELIVER;
                end else if (tmo_q == TMO_LAST) begin
                    req_n   = 1'b0;
                    instr_n = NOP;
                    err_n   = ERR_TIMEOUT;
                    state_n = HALT;
                end else begin
                    tmo_n = tmo_q + TMO_WIDTH'(1);
                end
            end
            DELIVER: begin
                cnt_n   = cnt_q + CNT_WIDTH'(1);
                state_n = ISSUE;
            end
            HALT: begin
                req_n = 1'b0;
            end
            default: begin
                state_n = ISSUE;
            end
        endcase
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign pc_en        = pc_en_q;
    assign fetch_cnt    = cnt_q;
    assign err_code     = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// A transaction-level model predicts each fetch from its ack delay.
// The fetched word, the request window length and the fetch count are checked.
// The count is checked modulo 2^CNT_WIDTH.
module tb_instr_fetch_unit;

    localparam int          TMO   = 8;
    localparam int          CW    = 3;
    localparam logic [31:0] NOPV  = 32'h0000_0013;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          fetch_en = 1'b0;
    logic [31:0]   pc_addr = '0;
    logic          pc_en;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [CW-1:0] fetch_cnt;
    logic [1:0]    err_code;

    int checkCount = 0;
    int passCount  = 0;
    int expCount   = 0;

    instr_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .TIMEOUT(TMO), .CNT_WIDTH(CW), .NOP(NOPV)
    ) dut (
        .CLK(CLK), .RST(RST), .fetch_en(fetch_en), .pc_addr(pc_addr), .pc_en(pc_en),
        .instr(instr), .instr_valid(instr_valid), .fetch_cnt(fetch_cnt),
        .err_code(err_code), .mem(bus)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h required %h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST = 1'b0;
        fetch_en = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) tick();
        RST = 1'b1;
        expCount = 0;
    endtask

    // One complete fetch: idle cycles in ISSUE, issue, ackDelay empty WAIT cycles, ack, deliver
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] rdata,
                                 input int ackDelay, input int idle, input bit dropEn);
        for (int i = 0; i < idle; i++) begin
            fetch_en = 1'b0;
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            tick();
            checkOutput("idle_req", 32'(bus.mem_req), 32'd0);
            checkOutput("idle_pc_en", 32'(pc_en), 32'd0);
        end
        pc_addr = pc;
        fetch_en = 1'b1;
        bus.mem_ack = 1'b0;
        tick();
        if (dropEn) fetch_en = 1'b0;
        for (int k = 0; k <= ackDelay; k++) begin
            checkOutput("wait_req", 32'(bus.mem_req), 32'd1);
            checkOutput("wait_addr", bus.mem_addr, pc);
            checkOutput("wait_pc_en", 32'(pc_en), 32'd0);
            checkOutput("wait_valid", 32'(instr_valid), 32'd0);
            bus.mem_ack = (k == ackDelay);
            bus.mem_rdata = (k == ackDelay) ? rdata : $urandom;
            tick();
        end
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
        checkOutput("dlv_valid", 32'(instr_valid), 32'd1);
        checkOutput("dlv_pc_en", 32'(pc_en), 32'd1);
        checkOutput("dlv_instr", instr, rdata);
        checkOutput("dlv_req", 32'(bus.mem_req), 32'd0);
        checkOutput("dlv_err", 32'(err_code), 32'd0);
        expCount++;
        fetch_en = 1'b0;
        tick();
        checkOutput("post_valid", 32'(instr_valid), 32'd0);
        checkOutput("post_pc_en", 32'(pc_en), 32'd0);
        checkOutput("post_instr", instr, rdata);
        checkOutput("post_cnt", 32'(fetch_cnt), 32'(expCount % (1 << CW)));
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        doReset();

        $display("[TB] reset values");
        checkOutput("rst_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_instr", instr, NOPV);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
        checkOutput("rst_cnt", 32'(fetch_cnt), 32'd0);
        checkOutput("rst_err", 32'(err_code), 32'd0);

        $display("[TB] directed fetches");
        applyStimulus(32'h0, 32'h2008_0005, 0, 0, 1'b0);
        applyStimulus(32'h4, 32'h1234_5678, 4, 5, 1'b0);
        applyStimulus(32'h8, 32'hCAFE_0001, 2, 1, 1'b1);

        $display("[TB] random fetches");
        for (int n = 0; n < 24; n++) begin
            applyStimulus($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, TMO - 2),
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during WAIT");
        pc_addr = 32'h0000_0040;
        fetch_en = 1'b1;
        bus.mem_ack = 1'b0;
        tick();
        tick();
        #2 RST = 1'b0;
        #1;
        checkOutput("arst_req", 32'(bus.mem_req), 32'd0);
        checkOutput("arst_addr", bus.mem_addr, 32'd0);
        checkOutput("arst_instr", instr, NOPV);
        checkOutput("arst_cnt", 32'(fetch_cnt), 32'd0);
        checkOutput("arst_err", 32'(err_code), 32'd0);
        fetch_en = 1'b0;
        tick();
        RST = 1'b1;
        expCount = 0;
        tick();
        checkOutput("arst_idle_req", 32'(bus.mem_req), 32'd0);
        applyStimulus(32'h80, 32'hA5A5_5A5A, 1, 0, 1'b0);

        $display("[TB] counter wrap");
        doReset();
        for (int n = 0; n < 9; n++) begin
            applyStimulus(32'(n * 4), $urandom, $urandom_range(0, 2), 0, 1'b0);
        end
        checkOutput("wrap_cnt", 32'(fetch_cnt), 32'd1);

        $display("[TB] timeout");
        doReset();
        applyStimulus(32'h100, 32'hDEAD_BEEF, 0, 0, 1'b0);
        pc_addr = 32'h104;
        fetch_en = 1'b1;
        bus.mem_ack = 1'b0;
        tick();
        for (int w = 1; w <= TMO; w++) begin
            checkOutput("tmo_wait_req", 32'(bus.mem_req), 32'd1);
            checkOutput("tmo_wait_err", 32'(err_code), 32'd0);
            tick();
        end
        checkOutput("tmo_err", 32'(err_code), 32'd1);
        checkOutput("tmo_req", 32'(bus.mem_req), 32'd0);
        checkOutput("tmo_instr", instr, NOPV);
        for (int i = 0; i < 20; i++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            tick();
            checkOutput("halt_req", 32'(bus.mem_req), 32'd0);
            checkOutput("halt_pc_en", 32'(pc_en), 32'd0);
            checkOutput("halt_valid", 32'(instr_valid), 32'd0);
        end
        checkOutput("halt_err", 32'(err_code), 32'd1);

        $display("[TB] misaligned PC");
        doReset();
        pc_addr = 32'h6;
        fetch_en = 1'b1;
        tick();
        checkOutput("mis_err", 32'(err_code), 32'd2);
        checkOutput("mis_req", 32'(bus.mem_req), 32'd0);
        pc_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("mis_halt_req", 32'(bus.mem_req), 32'd0);
            checkOutput("mis_halt_pc_en", 32'(pc_en), 32'd0);
        end
        checkOutput("mis_err_sticky", 32'(err_code), 32'd2);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
